// File: rtl/midi_tick_scheduler.sv
// MIDI sequencer front-end: programs the interval timer, turns timeouts into ticks, releases queued events.
// Optional `define MIDI_SCHED_QUEUE_EN: 4-entry event FIFO instead of a single holding register.
`timescale 1ns/1ps
module midi_tick_scheduler #(
  parameter int MIN_PERIOD = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cfg_period,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  output logic        running,
  output logic        busy,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic        tmr_irq,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_delta,
  input  logic [23:0] in_msg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_msg,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic [2:0]  state_dbg
);

  // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
  // valid does not depend on ready, and a held valid keeps its payload stable.

  typedef enum logic [2:0] {IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR, CLR_WAIT, STOP_WR} state_t;

  localparam logic [31:0] MIN_PERIOD_W = 32'(MIN_PERIOD);

`ifdef MIDI_SCHED_QUEUE_EN
  localparam logic [2:0] DEPTH = 3'd4;
`else
  localparam logic [2:0] DEPTH = 3'd1;
`endif
  localparam logic [1:0] LAST = DEPTH[1:0] - 2'd1;

  state_t      state;
  logic [15:0] period_hi;
  logic [31:0] period_clamped;

  assign period_clamped = (cfg_period < MIN_PERIOD_W) ? MIN_PERIOD_W : cfg_period;
  assign state_dbg      = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      period_hi      <= '0;
      running        <= 1'b0;
      busy           <= 1'b0;
      tmr_address    <= '0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= '0;
      tick           <= 1'b0;
      tick_count     <= '0;
    end else begin
      tmr_address    <= '0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= '0;
      tick           <= 1'b0;
      // Stop wins over everything outside IDLE; a timeout seen in the same cycle is dropped.
      if (state != IDLE && cfg_stop) begin
        state          <= STOP_WR;
        running        <= 1'b0;
        busy           <= 1'b1;
        tmr_chipselect <= 1'b1;
        tmr_write_n    <= 1'b0;
        tmr_address    <= 3'd1;
        tmr_writedata  <= 16'h0008;
      end else begin
        case (state)
          IDLE: if (cfg_start) begin
            state          <= WR_PL;
            busy           <= 1'b1;
            period_hi      <= period_clamped[31:16];
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_address    <= 3'd2;
            tmr_writedata  <= period_clamped[15:0];
          end
          WR_PL: begin
            state          <= WR_PH;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_address    <= 3'd3;
            tmr_writedata  <= period_hi;
          end
          WR_PH: begin
            state          <= WR_CTL;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_address    <= 3'd1;
            tmr_writedata  <= 16'h0007;
          end
          WR_CTL: begin
            state   <= RUN;
            running <= 1'b1;
            busy    <= 1'b0;
          end
          RUN: if (tmr_irq) begin
            state          <= CLR;
            busy           <= 1'b1;
            tick           <= 1'b1;
            tick_count     <= tick_count + 32'd1;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
          end
          CLR:      state <= CLR_WAIT;
          CLR_WAIT: begin
            state <= RUN;
            busy  <= 1'b0;
          end
          STOP_WR: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Event queue; with DEPTH 1 the pointers stay at entry 0 and it acts as a holding register.
  logic [23:0] msg_mem [4];
  logic [15:0] dly_mem [4];
  logic [1:0]  rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [2:0]  count;
  logic [15:0] remaining;
  logic        push, pop;

  assign in_ready  = (count != DEPTH);
  assign out_valid = (count != 3'd0) && (remaining == 16'd0);
  assign out_msg   = (count != 3'd0) ? msg_mem[rd_ptr] : 24'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign rd_nxt    = (rd_ptr == LAST) ? 2'd0 : rd_ptr + 2'd1;
  assign wr_nxt    = (wr_ptr == LAST) ? 2'd0 : wr_ptr + 2'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
      for (int i = 0; i < 4; i++) begin
        msg_mem[i] <= '0;
        dly_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        msg_mem[wr_ptr] <= in_msg;
        dly_mem[wr_ptr] <= in_delta;
        wr_ptr          <= wr_nxt;
      end
      if (pop) rd_ptr <= rd_nxt;
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
      // A freshly loaded head never sees the tick of the edge that loaded it.
      if (pop) begin
        if (count > 3'd1) remaining <= dly_mem[rd_nxt];
        else if (push)    remaining <= in_delta;
      end else if (push && count == 3'd0) begin
        remaining <= in_delta;
      end else if (tick && count != 3'd0 && remaining != 16'd0) begin
        remaining <= remaining - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_midi_tick_scheduler.sv
// Directed bench for midi_tick_scheduler: timer programming, tick service, stop priority and event release.
`timescale 1ns/1ps
module tb_midi_tick_scheduler;

`ifdef MIDI_SCHED_QUEUE_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cfg_period = '0;
  logic        cfg_start = 1'b0, cfg_stop = 1'b0;
  logic        running, busy;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect, tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] in_delta = '0;
  logic [23:0] in_msg = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [23:0] out_msg;
  logic        tick;
  logic [31:0] tick_count;
  logic [2:0]  state_dbg;

  int tests = 0, fails = 0, cyc = 0;
  logic [31:0] exp_ticks = '0;
  logic [18:0] wr_q[$];
  logic [18:0] exp_q[$];

  // Simple interval-timer model; the bench can override irq manually.
  logic        use_model = 1'b0, irq_man = 1'b0, irq_m, t_run;
  logic [15:0] t_pl, t_ph;
  logic [31:0] t_cnt;
  assign tmr_irq = use_model ? irq_m : irq_man;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_run <= 1'b0; irq_m <= 1'b0; t_cnt <= '0; t_pl <= '0; t_ph <= '0;
    end else begin
      if (t_run) begin
        if (t_cnt == 0) begin irq_m <= 1'b1; t_cnt <= {t_ph, t_pl}; end
        else t_cnt <= t_cnt - 1;
      end
      if (tmr_chipselect && !tmr_write_n) begin
        wr_q.push_back({tmr_address, tmr_writedata});
        case (tmr_address)
          3'd0: irq_m <= 1'b0;
          3'd1: if (tmr_writedata[3]) begin t_run <= 1'b0; irq_m <= 1'b0; end
                else if (tmr_writedata[2]) begin t_run <= 1'b1; t_cnt <= {t_ph, t_pl}; end
          3'd2: t_pl <= tmr_writedata;
          3'd3: t_ph <= tmr_writedata;
          default: ;
        endcase
      end
    end
  end

  midi_tick_scheduler #(.MIN_PERIOD(16)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_period(cfg_period), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .running(running), .busy(busy), .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq),
    .in_valid(in_valid), .in_ready(in_ready), .in_delta(in_delta), .in_msg(in_msg),
    .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg),
    .tick(tick), .tick_count(tick_count), .state_dbg(state_dbg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fsm();
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    step(); step(); step();
  endtask

  task automatic stop_fsm();
    cfg_stop = 1'b1; step(); cfg_stop = 1'b0; step();
  endtask

  task automatic test_reset();
    step(); step();
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL reset_running: got %0h want 0", running); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0h want 0", busy); end
    tests++; if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b0, 1'b1, 3'd0, 16'h0})
      begin fails++; $display("FAIL reset_bus: got cs=%0h wn=%0h a=%0h d=%0h want 0/1/0/0", tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata); end
    tests++; if ({tick, tick_count} !== 33'd0) begin fails++; $display("FAIL reset_tick: got %0h/%0h want 0/0", tick, tick_count); end
    tests++; if ({in_ready, out_valid, out_msg} !== {1'b1, 1'b0, 24'h0})
      begin fails++; $display("FAIL reset_queue: got rdy=%0h ov=%0h msg=%0h want 1/0/0", in_ready, out_valid, out_msg); end
    reset_n = 1'b1;
    step();
    tests++; if (state_dbg !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
  endtask

  task automatic test_start();
    cfg_period = 32'h0001_86A0;
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    tests++; if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, 3'd2, 16'h86A0})
      begin fails++; $display("FAIL start_wr_pl: got a=%0h d=%0h cs=%0h wn=%0h want a=2 d=86a0", tmr_address, tmr_writedata, tmr_chipselect, tmr_write_n); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL start_busy: got %0h want 1", busy); end
    step();
    tests++; if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, 3'd3, 16'h0001})
      begin fails++; $display("FAIL start_wr_ph: got a=%0h d=%0h want a=3 d=0001", tmr_address, tmr_writedata); end
    step();
    tests++; if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, 3'd1, 16'h0007})
      begin fails++; $display("FAIL start_wr_ctl: got a=%0h d=%0h want a=1 d=0007", tmr_address, tmr_writedata); end
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL start_running_early: got %0h want 0", running); end
    step();
    tests++; if ({running, busy, tmr_chipselect, tmr_write_n} !== 4'b1001)
      begin fails++; $display("FAIL start_run: got run=%0h busy=%0h cs=%0h wn=%0h want 1/0/0/1", running, busy, tmr_chipselect, tmr_write_n); end
  endtask

  task automatic test_service();
    int ticks_seen = 0;
    irq_man = 1'b1; step();
    exp_ticks++;
    if (tick === 1'b1) ticks_seen++;
    tests++; if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, 3'd0, 16'h0})
      begin fails++; $display("FAIL service_clr_write: got cs=%0h a=%0h d=%0h want cs=1 a=0 d=0", tmr_chipselect, tmr_address, tmr_writedata); end
    tests++; if (tick_count !== exp_ticks) begin fails++; $display("FAIL service_count: got %0d want %0d", tick_count, exp_ticks); end
    step();
    if (tick === 1'b1) ticks_seen++;
    tests++; if ({busy, tmr_chipselect} !== 2'b10) begin fails++; $display("FAIL service_wait: got busy=%0h cs=%0h want 1/0", busy, tmr_chipselect); end
    step();
    if (tick === 1'b1) ticks_seen++;
    irq_man = 1'b0;
    tests++; if (state_dbg !== 3'd4) begin fails++; $display("FAIL service_back_run: got %0d want 4", state_dbg); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (tick === 1'b1) ticks_seen++;
    end
    tests++; if (ticks_seen != 1) begin fails++; $display("FAIL service_single_tick: got %0d want 1", ticks_seen); end
    tests++; if (tick_count !== exp_ticks) begin fails++; $display("FAIL service_no_double: got %0d want %0d", tick_count, exp_ticks); end
  endtask

  task automatic test_stop_vs_irq();
    irq_man = 1'b1; cfg_stop = 1'b1; step(); irq_man = 1'b0; cfg_stop = 1'b0;
    tests++; if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, 3'd1, 16'h0008})
      begin fails++; $display("FAIL stop_write: got a=%0h d=%0h cs=%0h want a=1 d=0008 cs=1", tmr_address, tmr_writedata, tmr_chipselect); end
    tests++; if ({tick, running} !== 2'b00) begin fails++; $display("FAIL stop_tick_run: got tick=%0h run=%0h want 0/0", tick, running); end
    tests++; if (tick_count !== exp_ticks) begin fails++; $display("FAIL stop_count: got %0d want %0d", tick_count, exp_ticks); end
    step();
    tests++; if ({state_dbg, busy, tmr_chipselect} !== {3'd0, 1'b0, 1'b0})
      begin fails++; $display("FAIL stop_idle: got st=%0d busy=%0h cs=%0h want 0/0/0", state_dbg, busy, tmr_chipselect); end
  endtask

  task automatic test_clamp_period();
    int wr_base, prev, n;
    wr_base = wr_q.size();
    use_model = 1'b1;
    cfg_period = 32'd3;
    start_fsm();
    exp_q.delete();
    exp_q.push_back({3'd2, 16'h0010}); exp_q.push_back({3'd3, 16'h0000}); exp_q.push_back({3'd1, 16'h0007});
    tests++; if (wr_q.size() - wr_base != 3) begin fails++; $display("FAIL clamp_nwrites: got %0d want 3", wr_q.size() - wr_base); end
    else for (int k = 0; k < 3; k++) begin
      tests++; if (wr_q[wr_base + k] !== exp_q[k]) begin fails++; $display("FAIL clamp_write%0d: got %0h want %0h", k, wr_q[wr_base + k], exp_q[k]); end
    end
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (tick !== 1'b1 && n < 100) begin step(); n++; end
      if (n >= 100) begin
        tests++; fails++; $display("FAIL clamp_tick_timeout: got no tick %0d want tick", k);
        break;
      end
      exp_ticks++;
      if (k > 0) begin
        tests++; if (cyc - prev != 17) begin fails++; $display("FAIL clamp_interval: got %0d want 17", cyc - prev); end
      end
      prev = cyc;
      step();
    end
    tests++; if (tick_count !== exp_ticks) begin fails++; $display("FAIL clamp_count: got %0d want %0d", tick_count, exp_ticks); end
    stop_fsm();
    use_model = 1'b0;
  endtask

  task automatic tick_pulse();
    irq_man = 1'b1; step(); irq_man = 1'b0;
    exp_ticks++;
    tests++; if (tick !== 1'b1) begin fails++; $display("FAIL queue_tick: got %0h want 1", tick); end
    step(); step();
  endtask

  task automatic test_queue();
    out_ready = 1'b0;
    in_valid = 1'b1; in_delta = 16'd0; in_msg = 24'h903C64; step(); in_valid = 1'b0;
    tests++; if ({out_valid, out_msg} !== {1'b1, 24'h903C64}) begin fails++; $display("FAIL queue_delta0: got ov=%0h msg=%0h want 1/903c64", out_valid, out_msg); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL queue_pop_a: got %0h want 0", out_valid); end
    in_valid = 1'b1; in_delta = 16'd3; in_msg = 24'h803C00; step(); in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL queue_b_wait: got %0h want 0", out_valid); end
    start_fsm();
    for (int k = 1; k <= 3; k++) begin
      tick_pulse();
      tests++; if (out_valid !== (k == 3)) begin fails++; $display("FAIL queue_b_tick%0d: got ov=%0h want %0h", k, out_valid, (k == 3)); end
    end
    tests++; if (out_msg !== 24'h803C00) begin fails++; $display("FAIL queue_b_msg: got %0h want 803c00", out_msg); end
    tick_pulse(); tick_pulse();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL queue_b_hold: got %0h want 1", out_valid); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    in_valid = 1'b1; in_delta = 16'd1; in_msg = 24'h913E40; step(); in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL queue_no_bank: got %0h want 0", out_valid); end
    tick_pulse();
    tests++; if ({out_valid, out_msg} !== {1'b1, 24'h913E40}) begin fails++; $display("FAIL queue_c_out: got ov=%0h msg=%0h want 1/913e40", out_valid, out_msg); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    stop_fsm();
    tests++; if (tick_count !== exp_ticks) begin fails++; $display("FAIL queue_count: got %0d want %0d", tick_count, exp_ticks); end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    out_ready = 1'b0; in_delta = 16'd0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_msg = 24'h900000 + 24'(i);
      exp_rdy = (i < DEPTH);
      tests++; if (in_ready !== exp_rdy) begin fails++; $display("FAIL fill_ready%0d: got %0h want %0h", i, in_ready, exp_rdy); end
      step();
    end
    in_msg = 24'hAAAAAA; out_ready = 1'b1;
    tests++; if ({in_ready, out_valid, out_msg} !== {1'b0, 1'b1, 24'h900000})
      begin fails++; $display("FAIL full_pushpop: got rdy=%0h ov=%0h msg=%0h want 0/1/900000", in_ready, out_valid, out_msg); end
    step(); in_valid = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      tests++; if ({out_valid, out_msg} !== {1'b1, 24'h900000 + 24'(i)})
        begin fails++; $display("FAIL drain%0d: got ov=%0h msg=%0h want 1/%0h", i, out_valid, out_msg, 24'h900000 + 24'(i)); end
      step();
    end
    out_ready = 1'b0;
    tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL drain_empty: got ov=%0h rdy=%0h want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_write();
    in_valid = 1'b1; in_delta = 16'd5; in_msg = 24'h123456; step(); in_valid = 1'b0;
    cfg_period = 32'h0000_1234;
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    step();
    reset_n = 1'b0; #2;
    tests++; if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, busy} !== {1'b0, 1'b1, 3'd0, 16'h0, 1'b0})
      begin fails++; $display("FAIL async_reset_bus: got cs=%0h wn=%0h a=%0h d=%0h busy=%0h want 0/1/0/0/0", tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, busy); end
    tests++; if ({in_ready, tick_count} !== {1'b1, 32'd0}) begin fails++; $display("FAIL async_reset_flush: got rdy=%0h cnt=%0d want 1/0", in_ready, tick_count); end
    step(); reset_n = 1'b1; step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_service();
    test_stop_vs_irq();
    test_clamp_period();
    test_queue();
    test_back_to_back();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/midi_tick_scheduler.md
# midi_tick_scheduler

Sequencer front-end for the 16-bit Avalon-MM interval timer in the MIDI library. It owns the timer's slave port: it programs period and control, services each timeout interrupt, and turns it into a one-cycle `tick`. It releases queued 3-byte MIDI messages when each message's delta-time, in ticks, has elapsed.

## Interface
Parameters:
- MIN_PERIOD, 16: smallest period value written to the timer; smaller `cfg_period` values are clamped up to it.

Ports:
- clk  in  1  system clock, same clock as the timer.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_period  in  32  timer period; the tick interval is cfg_period+1 clocks.
- cfg_start  in  1  pulse: program the timer and start it.
- cfg_stop  in  1  pulse: stop the timer.
- running  out  1  the timer is programmed and ticks are being serviced.
- busy  out  1  the state machine is in any state other than IDLE or RUN.
- tmr_address  out  3  timer register address.
- tmr_chipselect  out  1  timer chip select.
- tmr_write_n  out  1  timer write strobe, active low.
- tmr_writedata  out  16  timer write data.
- tmr_irq  in  1  timer timeout interrupt, level.
- in_valid / in_ready  in / out  1 / 1  event push handshake.
- in_delta  in  16  ticks to wait after the previous emission.
- in_msg  in  24  MIDI message, status byte in [23:16].
- out_valid / out_ready  out / in  1 / 1  event pop handshake.
- out_msg  out  24  the released message.
- tick  out  1  one-cycle pulse per serviced timeout.
- tick_count  out  32  serviced timeouts since reset; wraps.

## Operation
- States: IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR, CLR_WAIT, STOP_WR.
- IDLE + cfg_start: latch max(cfg_period, MIN_PERIOD), then go to WR_PL.
- WR_PL writes addr 2 with the period's low half. WR_PH writes addr 3 with the high half. WR_CTL writes addr 1 with 0x0007 (START, CONT, ITO). Then go to RUN.
- RUN + tmr_irq: go to CLR, which writes addr 0 with 0x0000 and pulses `tick`. Then CLR_WAIT, one idle bus cycle while the irq deasserts. Then back to RUN.
- cfg_stop in any state except IDLE: go to STOP_WR, which writes addr 1 with 0x0008 (STOP). Then IDLE.
- Priorities:
  - In IDLE, cfg_start beats cfg_stop; cfg_stop alone is ignored.
  - In every other state, cfg_stop beats cfg_start and tmr_irq; the pending tick is dropped.
  - cfg_start outside IDLE is ignored.
- Idle bus: chipselect=0, write_n=1, address=0, writedata=0.
- Each write cycle drives chipselect=1, write_n=0 for exactly one cycle. The timer has no waitrequest.
- Event queue:
  - The queue is a FIFO; in_ready = !full.
  - The head's `remaining` counter loads in_delta when the entry becomes head.
  - Each tick decrements `remaining`, saturating at 0.
  - When the head is valid and remaining==0, out_valid=1 with out_msg = the head's message, held until out_ready.
  - Ticks arriving while the head is waiting at remaining==0 are discarded, not banked.
  - Delta 0 means release with no tick needed.
- Stop does not flush the queue; countdown freezes because no ticks arrive. Only reset flushes the queue.
- tick_count increments in the CLR cycle and wraps 0xFFFFFFFF -> 0.

## Timing
- Reset values:
  - state IDLE; running=0, busy=0.
  - tmr_* idle values; tick=0, tick_count=0.
  - queue empty; in_ready=1, out_valid=0, out_msg=0.
- Start latency: cfg_start seen at cycle 0 gives writes at cycles 1, 2, 3. running=1 from cycle 4.
- Service latency: tmr_irq high at cycle n gives the CLR write and `tick` at n+1, CLR_WAIT at n+2, and RUN at n+3. tmr_irq is not sampled in CLR or CLR_WAIT.
- Stop latency: cfg_stop at cycle n gives the STOP write at n+1 and IDLE at n+2. running=0 from n+1.
- Push: an entry is accepted on the edge where in_valid && in_ready.
- Push into an empty queue: out_valid rises the next cycle if in_delta==0.
- Pop: the entry is removed on the edge where out_valid && out_ready. The next head loads `remaining` that same edge.
- A pop and a tick on the same edge: the tick is not applied to the newly loaded head.
- Push and pop on the same edge while full: the push is refused, because in_ready was 0.
- Reset mid-write: the bus returns to idle immediately, asynchronously. The timer is reset by the same reset_n.

## Configuration
- MIDI_SCHED_QUEUE_EN defined: the event queue is a 4-entry FIFO.
- Not defined: the queue is a single holding register, in_ready = !out_valid_pending. All other behaviour is identical.

## Test plan
- Reset, then cfg_start with cfg_period=0x0001_86A0 -> writes in order: (2, 0x86A0), (3, 0x0001), (1, 0x0007); running=1 four cycles after cfg_start.
- cfg_period=3 -> period words written are 0x0010 and 0x0000 (clamped); running timer ticks every 17 clocks; tick_count=5 after the 5th irq.
- Irq held high for 2 cycles beyond the CLR write -> exactly one tick and one (0, 0x0000) write per timeout; no double count.
- Push (delta=0, 0x903C64) then (delta=3, 0x803C00) -> first message out before any tick; second out_valid exactly on the 3rd tick after the first pop.
- cfg_stop asserted the same cycle as tmr_irq in RUN -> write (1, 0x0008), no tick, tick_count unchanged, IDLE two cycles later.
- With MIDI_SCHED_QUEUE_EN, push 5 events with out_ready=0 -> in_ready drops after the 4th; without the macro, it drops after the 1st.
